// File: rtl/qif_pkg.sv
// Shared fixed-point constants, helper functions and the result record
// used by the QIF neuron array.
package qif_pkg;

    localparam int QIF_WIDTH   = 16;
    localparam int QIF_FRAC    = 8;
    localparam int QIF_N_CH    = 4;
    localparam int QIF_CH_W    = (QIF_N_CH > 1) ? $clog2(QIF_N_CH) : 1;
    localparam int V_RESET_DEF = -512;
    localparam int V_PEAK_DEF  = 2048;
    localparam int ACC_MAX     = 64;

    // Wide enough for v*v plus the drive term without overflow.
    function automatic int acc_width(input int width);
        return 2 * width + 2;
    endfunction

    function automatic logic signed [ACC_MAX-1:0] sat_to_width(
        input logic signed [ACC_MAX-1:0] x,
        input int                        width
    );
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

    // Sized for the default array configuration.
    typedef struct packed {
        logic [QIF_CH_W-1:0]         ch;
        logic signed [QIF_WIDTH-1:0] v;
        logic                        spike;
    } qif_result_t;

endpackage

// File: rtl/qif_update_core.sv
// One QIF integration step for a single channel: quadratic term, gain shift,
// saturation, peak detection and refractory countdown. Purely combinational.
module qif_update_core
    import qif_pkg::*;
#(
    parameter int WIDTH   = QIF_WIDTH,
    parameter int FRAC    = QIF_FRAC,
    parameter int A_SHIFT = 2,
    parameter int V_RESET = V_RESET_DEF,
    parameter int V_PEAK  = V_PEAK_DEF,
    parameter int REFRAC  = 3,
    parameter int CNT_W   = 2
) (
    input  logic signed [WIDTH-1:0] v_i,
    input  logic signed [WIDTH-1:0] b_i,
    input  logic [CNT_W-1:0]        cnt_i,
    output logic signed [WIDTH-1:0] v_next_o,
    output logic [CNT_W-1:0]        cnt_next_o,
    output logic signed [WIDTH-1:0] out_v_o,
    output logic                    spike_o
);

    localparam int ACC_W = acc_width(WIDTH);

    logic signed [ACC_W-1:0] v_ext;
    logic signed [ACC_W-1:0] sq;
    logic signed [ACC_W-1:0] d;
    logic signed [ACC_W-1:0] v_sum;
    logic signed [WIDTH-1:0] vn;

    // NOTE: every output gets a default before any branch so no latch can be inferred.
    always_comb begin
        v_next_o   = WIDTH'(V_RESET);
        cnt_next_o = '0;
        out_v_o    = WIDTH'(V_RESET);
        spike_o    = 1'b0;

        v_ext = ACC_W'(v_i);
        sq    = (v_ext * v_ext) >>> FRAC;
        d     = (sq + ACC_W'(b_i)) >>> A_SHIFT;
        v_sum = v_ext + d;
        vn    = WIDTH'(sat_to_width(ACC_MAX'(v_sum), WIDTH));

        if (cnt_i != '0) begin
            // Refractory: hold at reset potential and ignore the drive.
            cnt_next_o = cnt_i - CNT_W'(1);
        end else if (vn >= WIDTH'(V_PEAK)) begin
            cnt_next_o = CNT_W'(REFRAC);
            out_v_o    = WIDTH'(V_PEAK);
            spike_o    = 1'b1;
        end else begin
            v_next_o = vn;
            out_v_o  = vn;
        end
    end

endmodule

// File: rtl/qif_neuron_array.sv
// N_CH QIF neurons sharing one update core; per-channel state arrays,
// valid/ready input and a single-entry registered output.
module qif_neuron_array
    import qif_pkg::*;
#(
    parameter int WIDTH   = QIF_WIDTH,
    parameter int FRAC    = QIF_FRAC,
    parameter int N_CH    = QIF_N_CH,
    parameter int A_SHIFT = 2,
    parameter int V_RESET = V_RESET_DEF,
    parameter int V_PEAK  = V_PEAK_DEF,
    parameter int REFRAC  = 3,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_ch,
    input  logic signed [WIDTH-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic signed [WIDTH-1:0] out_v,
    output logic                    out_spike
);

    localparam int CNT_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic signed [WIDTH-1:0] v_q   [N_CH];
    logic [CNT_W-1:0]        cnt_q [N_CH];
    logic                    out_valid_q;
    qif_result_t             res_q;

    logic                    accept;
    logic                    ch_ok;
    logic signed [WIDTH-1:0] core_v_next;
    logic [CNT_W-1:0]        core_cnt_next;
    logic signed [WIDTH-1:0] core_out_v;
    logic                    core_spike;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign ch_ok    = int'(in_ch) < N_CH;

    qif_update_core #(
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .A_SHIFT (A_SHIFT),
        .V_RESET (V_RESET),
        .V_PEAK  (V_PEAK),
        .REFRAC  (REFRAC),
        .CNT_W   (CNT_W)
    ) u_core (
        .v_i        (v_q[in_ch]),
        .b_i        (in_b),
        .cnt_i      (cnt_q[in_ch]),
        .v_next_o   (core_v_next),
        .cnt_next_o (core_cnt_next),
        .out_v_o    (core_out_v),
        .spike_o    (core_spike)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: the state arrays are flops, not RAM, so they can and must be reset to V_RESET.
            for (int i = 0; i < N_CH; i++) begin
                v_q[i]   <= WIDTH'(V_RESET);
                cnt_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Out-of-range channels are consumed without touching state or output.
            if (accept && ch_ok) begin
                v_q[in_ch]   <= core_v_next;
                cnt_q[in_ch] <= core_cnt_next;
                out_valid_q  <= 1'b1;
                res_q        <= '{ch: in_ch, v: core_out_v, spike: core_spike};
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = res_q.ch;
    assign out_v     = res_q.v;
    assign out_spike = res_q.spike;

endmodule

// File: tb/tb_qif_neuron_array.sv
// Scoreboard bench for qif_neuron_array: directed samples push hand-computed
// results, a monitor pops and compares every transferred output.
module tb_qif_neuron_array;

    localparam int WIDTH = 16;
    localparam int N_CH  = 4;
    localparam int CH_W  = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [CH_W-1:0]         in_ch;
    logic signed [WIDTH-1:0] in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;
    logic signed [WIDTH-1:0] out_v;
    logic                    out_spike;

    typedef struct {
        int ch;
        int v;
        int spike;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    qif_neuron_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_v     (out_v),
        .out_spike (out_spike)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: a beat transfers at the next posedge when valid && ready here.
    always @(negedge clk) begin
        if (!rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(out_v), -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_ch", 32'(out_ch), e.ch);
                check("out_v", 32'(out_v), e.v);
                check("out_spike", 32'(out_spike), e.spike);
            end
        end
    end

    task automatic send(input int ch, input int b, input int ev, input int es);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = CH_W'(ch);
        in_b     = WIDTH'(b);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 1);
        end else begin
            sb.push_back('{ch: ch, v: ev, spike: es});
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_state_reset(input string tag);
        for (int i = 0; i < N_CH; i++) begin
            check({tag, "_v"}, 32'(dut.v_q[i]), -512);
            check({tag, "_cnt"}, 32'(dut.cnt_q[i]), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = 1'b0;
        in_ch     = '0;
        in_b      = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1 rst_n  = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_v", 32'(out_v), 0);
        check("rst_out_ch", 32'(out_ch), 0);
        check("rst_out_spike", 32'(out_spike), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check_state_reset("rst");
        @(negedge clk);
        rst_n = 1'b0;

        // First steps from the reset potential.
        send(0, 0, -256, 0);
        send(0, 0, -192, 0);

        // ch0 drive to spike and refractory, ch1 interleaved for isolation.
        do_reset();
        send(0, 1024, 0, 0);
        send(1, 0, -256, 0);
        send(0, 1024, 256, 0);
        send(1, 0, -192, 0);
        send(0, 1024, 576, 0);
        send(1, 0, -156, 0);
        send(0, 1024, 1156, 0);
        send(1, 0, -133, 0);
        send(0, 1024, 2048, 1);
        send(0, 1024, -512, 0);
        send(0, 1024, -512, 0);
        send(0, 1024, -512, 0);
        send(0, 1024, 0, 0);

        // Saturation: second step overflows to +max and spikes.
        send(2, -32768, -8448, 0);
        send(2, -32768, 2048, 1);

        // Backpressure: stall three cycles with a sample waiting.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(3, 0, -256, 0);
        fork
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 0);
                    check("bp_out_valid", 32'(out_valid), 1);
                    check("bp_out_v", 32'(out_v), -256);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
            send(3, 0, -192, 0);
        join

        // Reset asserted during a stall clears output and state without a clock edge.
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(2, 0, -512, 0);
        @(negedge clk);
        check("stall_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b1;
        sb.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_v", 32'(out_v), 0);
        check_state_reset("midrst");
        @(negedge clk);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        send(2, 0, -256, 0);

        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        check("drain_pending", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qif_neuron_array.md
Name: qif_neuron_array

Overview:
- N_CH quadratic integrate-and-fire (QIF) neurons sharing one time-multiplexed update datapath.
- Signed fixed-point membrane state per channel, with a gain shift, saturation, peak detection and a per-channel refractory counter.
- Each accepted input sample (channel, drive B) advances that channel one step and emits one result (V, spike) on a valid/ready output.
- Sits between the stimulus/synapse front end and the spike-event collector.

Parameters:
- WIDTH, 16, total bits of V and B (signed two's complement).
- FRAC, 8, fractional bits (1.0 = 2^FRAC).
- N_CH, 4, number of neurons; CH_W = max(1, clog2(N_CH)).
- A_SHIFT, 2, gain A = 2^-A_SHIFT applied to the derivative term.
- V_RESET, -512, reset/post-spike potential (-2.0).
- V_PEAK, 2048, spike threshold (8.0).
- REFRAC, 3, samples a channel is held at V_RESET after a spike (0 = none).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_ch  in  CH_W  target channel
- in_b  in  WIDTH  signed drive B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_ch  out  CH_W  channel of result
- out_v  out  WIDTH  signed membrane value after the step
- out_spike  out  1  step produced a spike

Behaviour:
- Reset: rst_n is asynchronous, active-high; clock is clk. While rst_n=1:
  - every v[ch] = V_RESET and every refractory count = 0;
  - out_valid = 0; out_ch, out_v and out_spike = 0.
  - A reset asserted mid-stream discards any pending result and all state.
- Handshake:
  - in_ready = !out_valid || out_ready (single-entry output register).
  - A sample is accepted on a clk edge with in_valid && in_ready.
  - Latency 1: out_valid rises on the accepting edge.
  - Output fields hold stable while out_valid && !out_ready.
  - Accept and drain on the same edge are allowed, giving back-to-back throughput of 1 sample per cycle.
- Per-accepted-sample update for ch = in_ch:
  - If cnt[ch] != 0: cnt[ch] -= 1, v[ch] stays V_RESET, out_v = V_RESET, out_spike = 0, in_b is ignored.
  - Else compute in at least 2*WIDTH+2 signed bits:
    - sq = (v*v) >>> FRAC (arithmetic shift, floor);
    - d = (sq + b) >>> A_SHIFT;
    - vn = sat_WIDTH(v + d), clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If vn >= V_PEAK (signed compare): out_spike = 1, out_v = V_PEAK, v[ch] = V_RESET, cnt[ch] = REFRAC.
  - Else: out_spike = 0, out_v = vn, v[ch] = vn.
- Channel independence: each step touches only the state of ch. Consecutive samples to the same channel use the freshly written state, with no hazard stall, because the update completes in one cycle.
- Out-of-range in_ch (>= N_CH, only possible when N_CH is not a power of two): the sample is accepted and dropped. No state change, no output.
- No combinational path from in_* to out_*. in_ready depends only on out_valid and out_ready.

Decomposition:
- qif_pkg holds:
  - the fixed-point constants (FRAC, default V_RESET and V_PEAK);
  - the accumulator width function;
  - a sat_to_width function;
  - a result struct {ch, v, spike}.
- One sub-module, qif_update_core: a purely combinational step taking (v, b, cnt) and returning (v_next, cnt_next, out_v, spike).
- The top level holds the state arrays, the handshake and the output register.

Test Plan (defaults):
- Reset then one sample ch0, b=0 -> out_v=-256, spike=0. A second sample ch0, b=0 -> out_v=-192.
- ch0 driven with b=1024 on six accepted samples -> out_v = 0, 256, 576, 1156, then 2048 with spike=1 on the 5th (vn=2717). The 6th result is -512 with spike=0 (refractory).
- Continue ch0 with b=1024 -> two more results of -512/spike=0, then the refractory period ends and the next result is 0.
- Interleave ch1 (b=0) between the ch0 samples above -> ch0 sequence unchanged; ch1 gives -256, -192, ... (isolation check).
- Saturation: ch2 with b=-32768 twice -> first -8448; the second step saturates to 32767 and gives spike=1, out_v=2048.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output stable, no sample lost. Assert rst_n mid-stall -> out_valid=0 and all v=-512 immediately, without waiting for a clk edge.
